// File: rtl/ocram_test_pkg.sv
// Shared types and constants for the OCRAM self-test master.
package ocram_test_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam int unsigned ERR_W  = 16;

  localparam logic [1:0] OP_FILL       = 2'b00;
  localparam logic [1:0] OP_CHECK      = 2'b01;
  localparam logic [1:0] OP_FILL_CHECK = 2'b10;

  localparam logic [ERR_W-1:0] ERR_CNT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ocram_pattern_gen.sv
// Word index, word address and pattern value counters shared by the
// write and compare paths. Address and pattern wrap naturally.
module ocram_pattern_gen
  import ocram_test_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DATA_W-1:0] seed,
  output logic [IDX_W-1:0]  index,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Load restarts at word 0; advance steps all three counters together.
  always_ff @(posedge clk) begin
    if (reset) begin
      index <= '0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      index <= '0;
      addr  <= base_addr;
      data  <= seed;
    end else if (advance) begin
      index <= index + IDX_W'(1);
      addr  <= addr + ADDR_W'(1);
      data  <= data + DATA_W'(1);
    end
  end

endmodule

// File: rtl/ocram_test_master.sv
// Avalon-MM bring-up master: fills an OCRAM word range with a counter
// pattern, reads it back and compares, or both, reporting mismatches.
module ocram_test_master
  import ocram_test_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic [ERR_W-1:0]      error_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest,
  input  logic                  avm_readdatavalid
);

  state_t              state;
  logic [1:0]          op_q;
  logic [IDX_W-1:0]    count_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   seed_q;

  logic [IDX_W-1:0]    pg_index;
  logic [ADDR_W-1:0]   pg_addr;
  logic [DATA_W-1:0]   pg_data;

  logic                start_ok_c;
  logic                last_c;
  logic                wr_acc_c;
  logic                rd_data_c;
  logic                pg_load_c;
  logic                pg_adv_c;
  logic [ADDR_W-1:0]   pg_base_c;
  logic [DATA_W-1:0]   pg_seed_c;

  // Counter control: load on accepted start and on the fill-to-check turnaround.
  assign start_ok_c = (state == ST_IDLE) && start;
  assign last_c     = (pg_index == (count_q - IDX_W'(1)));
  assign wr_acc_c   = (state == ST_WRITE) && !avm_waitrequest;
  assign rd_data_c  = (state == ST_READ_WAIT) && avm_readdatavalid;
  assign pg_load_c  = start_ok_c || (wr_acc_c && last_c);
  assign pg_adv_c   = (wr_acc_c || rd_data_c) && !last_c;
  assign pg_base_c  = start_ok_c ? base_addr : base_q;
  assign pg_seed_c  = start_ok_c ? seed : seed_q;

  ocram_pattern_gen u_pattern_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (pg_load_c),
    .advance   (pg_adv_c),
    .base_addr (pg_base_c),
    .seed      (pg_seed_c),
    .index     (pg_index),
    .addr      (pg_addr),
    .data      (pg_data)
  );

  assign avm_address    = pg_addr;
  assign avm_writedata  = pg_data;
  assign avm_byteenable = {(DATA_W/8){1'b1}};

  // Sequencer: command latch, bus requests, compare and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      error_count    <= '0;
      first_err_addr <= '0;
      op_q           <= OP_FILL;
      count_q        <= '0;
      base_q         <= '0;
      seed_q         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q           <= (op == 2'b11) ? OP_FILL_CHECK : op;
            count_q        <= word_count;
            base_q         <= base_addr;
            seed_q         <= seed;
            error_count    <= '0;
            first_err_addr <= '0;
            if (word_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              busy <= 1'b1;
              if (op == OP_CHECK) begin
                state    <= ST_READ_REQ;
                avm_read <= 1'b1;
              end else begin
                state     <= ST_WRITE;
                avm_write <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (!avm_waitrequest && last_c) begin
            avm_write <= 1'b0;
            if (op_q == OP_FILL) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_READ_REQ;
              avm_read <= 1'b1;
            end
          end
        end
        ST_READ_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_READ_WAIT;
          end
        end
        ST_READ_WAIT: begin
          if (avm_readdatavalid) begin
            if (avm_readdata != pg_data) begin
              if (error_count == '0) first_err_addr <= pg_addr;
              if (error_count != ERR_CNT_MAX) error_count <= error_count + ERR_W'(1);
            end
            if (last_c) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= ST_READ_REQ;
              avm_read <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ocram_test_master.sv
// Self-checking bench: OCRAM slave model with random stalls and stray
// readdatavalid, plus a per-command reference of expected bus traffic and results.
module tb_ocram_test_master;
  import ocram_test_pkg::*;

  localparam int unsigned MEM_WORDS = 1 << ADDR_W;

  logic                clk;
  logic                reset;
  logic                start;
  logic [1:0]          op;
  logic [ADDR_W-1:0]   base_addr;
  logic [ADDR_W:0]     word_count;
  logic [DATA_W-1:0]   seed;
  logic                busy;
  logic                done;
  logic [ERR_W-1:0]    error_count;
  logic [ADDR_W-1:0]   first_err_addr;
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  ocram_test_master dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .op                (op),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .seed              (seed),
    .busy              (busy),
    .done              (done),
    .error_count       (error_count),
    .first_err_addr    (first_err_addr),
    .avm_address       (avm_address),
    .avm_byteenable    (avm_byteenable),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model state
  logic [DATA_W-1:0] mem [MEM_WORDS];
  bit                stall_en = 0;
  bit                spur_en  = 0;
  int                stall_left = 0;
  bit                in_seq = 0;
  bit                rd_pending = 0;
  logic [DATA_W-1:0] rd_data;
  int                wr_cnt = 0;
  int                rd_cnt = 0;
  logic [ADDR_W-1:0] exp_base = '0;
  logic [DATA_W-1:0] exp_seed = '0;
  bit                prev_stalled = 0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_wdata;
  logic              prev_rd, prev_wr;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] ed;

  // OCRAM slave: stalls, latency-1 read return, stray readdatavalid, traffic checks
  always @(negedge clk) begin
    if (reset) begin
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      rd_pending        = 0;
      in_seq            = 0;
      prev_stalled      = 0;
    end else begin
      if (prev_stalled) begin
        check("hold_addr", 32'(avm_address), 32'(prev_addr));
        check("hold_read", 32'(avm_read), 32'(prev_rd));
        check("hold_write", 32'(avm_write), 32'(prev_wr));
        if (prev_wr) check("hold_wdata", 32'(avm_writedata), 32'(prev_wdata));
      end
      if (rd_pending) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd_data;
        rd_pending        = 0;
      end else begin
        avm_readdatavalid = spur_en && ($urandom_range(0, 3) == 0);
        avm_readdata      = 16'($urandom);
      end
      if (avm_read || avm_write) begin
        if (!in_seq) begin
          stall_left = stall_en ? int'($urandom_range(0, 3)) : 0;
          in_seq     = 1;
        end
        if (stall_left > 0) begin
          avm_waitrequest = 1'b1;
          stall_left--;
        end else begin
          avm_waitrequest = 1'b0;
          in_seq          = 0;
          if (avm_write) begin
            ea = exp_base + ADDR_W'(wr_cnt);
            ed = exp_seed + DATA_W'(wr_cnt);
            check("wr_addr", 32'(avm_address), 32'(ea));
            check("wr_data", 32'(avm_writedata), 32'(ed));
            mem[avm_address] = avm_writedata;
            wr_cnt++;
          end
          if (avm_read) begin
            ea = exp_base + ADDR_W'(rd_cnt);
            check("rd_addr", 32'(avm_address), 32'(ea));
            rd_data    = mem[avm_address];
            rd_pending = 1;
            rd_cnt++;
          end
        end
      end else begin
        avm_waitrequest = stall_en ? 1'($urandom) : 1'b0;
        in_seq          = 0;
      end
      prev_stalled = (avm_read || avm_write) && avm_waitrequest;
      prev_addr    = avm_address;
      prev_wdata   = avm_writedata;
      prev_rd      = avm_read;
      prev_wr      = avm_write;
    end
  end

  // Cycles from start edge to visible done for an unstalled latency-1 slave
  function automatic int exp_latency(input logic [1:0] o, input int c);
    if (c == 0) return 1;
    if (o == OP_FILL) return c + 1;
    if (o == OP_CHECK) return 2 * c + 1;
    return 3 * c + 1;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [ADDR_W-1:0] b, input int c,
                        input logic [DATA_W-1:0] s, input bit stall);
    int exp_err, exp_wr, exp_rd, lat, budget, busy_bad, bad;
    bit seen;
    logic [ADDR_W-1:0] exp_first, a;
    exp_err   = 0;
    exp_first = '0;
    if (o == OP_CHECK) begin
      for (int i = 0; i < c; i++) begin
        a = b + ADDR_W'(i);
        if (mem[a] != s + DATA_W'(i)) begin
          if (exp_err == 0) exp_first = a;
          exp_err++;
        end
      end
    end
    exp_wr   = (o == OP_CHECK) ? 0 : c;
    exp_rd   = (o == OP_FILL) ? 0 : c;
    stall_en = stall;
    wr_cnt   = 0;
    rd_cnt   = 0;
    exp_base = b;
    exp_seed = s;
    @(negedge clk);
    start = 1'b1; op = o; base_addr = b; word_count = 14'(c); seed = s;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); base_addr = 13'($urandom); word_count = 14'($urandom); seed = 16'($urandom);
    lat = 1; seen = 0; busy_bad = 0; budget = 12 * c + 20;
    while (lat < budget) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_bad++;
      start = (lat == 2);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    if (!stall) check("latency", 32'(lat), 32'(exp_latency(o, c)));
    check("busy_gap", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    check("error_count", 32'(error_count), 32'(exp_err));
    if (exp_err != 0) check("first_err_addr", 32'(first_err_addr), 32'(exp_first));
    check("write_count", 32'(wr_cnt), 32'(exp_wr));
    check("read_count", 32'(rd_cnt), 32'(exp_rd));
    // start during the done cycle must be ignored
    start = 1'b1; op = o; base_addr = b; word_count = 14'(c + 1); seed = s;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse_len", 32'(done), 32'd0);
    check("start_in_done", 32'({busy, avm_read, avm_write}), 32'd0);
    if (o != OP_CHECK) begin
      bad = 0;
      for (int i = 0; i < c; i++)
        if (mem[b + ADDR_W'(i)] != s + DATA_W'(i)) bad++;
      check("mem_pattern", 32'(bad), 32'd0);
    end
    spur_en = 0;
  endtask

  initial begin
    int d, c, nc;
    logic [1:0] o;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] s;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'($urandom);
    reset = 1'b1; start = 1'b0; op = '0; base_addr = '0; word_count = '0; seed = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({busy, done, avm_read, avm_write}), 32'd0);
    check("rst_err", 32'(error_count), 32'd0);
    check("rst_first", 32'(first_err_addr), 32'd0);
    check("rst_addr", 32'(avm_address), 32'd0);
    check("rst_wdata", 32'(avm_writedata), 32'd0);
    check("byteenable", 32'(avm_byteenable), 32'h3);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_FILL, 13'd0, 4, 16'h1234, 0);
    check("fill_w3", 32'(mem[3]), 32'h1237);

    run_op(OP_FILL_CHECK, 13'd8190, 4, 16'hFFFE, 0);
    check("wrap_w8191", 32'(mem[8191]), 32'hFFFF);
    check("wrap_w0", 32'(mem[0]), 32'h0000);

    for (int i = 0; i < 8; i++) mem[i] = 16'h0100 + 16'(i);
    mem[5] = 16'h0000;
    run_op(OP_CHECK, 13'd0, 8, 16'h0100, 0);
    check("corrupt_cnt", 32'(error_count), 32'd1);
    check("corrupt_addr", 32'(first_err_addr), 32'd5);

    spur_en = 1;
    run_op(OP_FILL_CHECK, 13'($urandom), 16, 16'($urandom), 1);

    run_op(OP_FILL_CHECK, 13'd100, 0, 16'h5555, 0);

    // reset in the middle of a long fill
    stall_en = 0; wr_cnt = 0; rd_cnt = 0; exp_base = 13'd0; exp_seed = 16'hA5A5;
    @(negedge clk);
    start = 1'b1; op = OP_FILL; base_addr = 13'd0; word_count = 14'd100; seed = 16'hA5A5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_write_active", 32'(avm_write), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ctrl", 32'({busy, done, avm_read, avm_write}), 32'd0);
    reset = 1'b0;
    d = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) d++;
    end
    check("no_done_after_rst", 32'(d), 32'd0);
    run_op(OP_FILL, 13'd50, 6, 16'h7000, 0);

    // randomized commands, some checks against deliberately corrupted ranges
    for (int t = 0; t < 10; t++) begin
      o = 2'($urandom);
      b = 13'($urandom);
      c = int'($urandom_range(1, 40));
      s = 16'($urandom);
      if (o == OP_CHECK && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < c; i++) mem[b + ADDR_W'(i)] = s + DATA_W'(i);
        nc = int'($urandom_range(0, 3));
        for (int k = 0; k < nc; k++)
          mem[b + ADDR_W'($urandom_range(0, c - 1))] = 16'($urandom);
      end
      spur_en = 1'($urandom);
      run_op(o, b, c, s, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ocram_test_master.md
# ocram_test_master

Avalon-MM master that drives the on-chip RAM slave from the other end of the bus. On a start command it fills a word range with a deterministic counter pattern, reads it back and compares, or both in sequence, and reports mismatch count and first failing address. It sits beside the processor on the system interconnect as a bring-up and self-test initiator for the 16-bit OCRAM.

## Interface
- ADDR_W, 13, word-address width (8192 words)
- DATA_W, 16, data width; byteenable width is DATA_W/8
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe
- op  in  2  00 fill, 01 check, 10 fill-then-check, 11 treated as 10
- base_addr  in  ADDR_W  first word address
- word_count  in  ADDR_W+1  words to process, 0..2^ADDR_W
- seed  in  DATA_W  pattern value for word 0
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse at completion
- error_count  out  16  mismatches in last check, saturates at 16'hFFFF
- first_err_addr  out  ADDR_W  address of first mismatch; valid when error_count != 0
- avm_address  out  ADDR_W  word address
- avm_byteenable  out  DATA_W/8  constant all-ones
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write data
- avm_readdata  in  DATA_W  read data
- avm_waitrequest  in  1  slave stall
- avm_readdatavalid  in  1  read data valid

## Operation
- Pattern: word i (0-based) = seed + i, mod 2^DATA_W. Address of word i = base_addr + i, mod 2^ADDR_W (wraps 8191 -> 0).
- States: IDLE, WRITE, READ_REQ, READ_WAIT, DONE.
- IDLE: start accepted; latch op, base_addr, word_count, seed; clear error_count and first_err_addr. word_count 0 -> DONE with no bus activity. op 00/10/11 -> WRITE; op 01 -> READ_REQ.
- WRITE: avm_write high, address/data for word i; advance i when waitrequest low; after last word, op 00 -> DONE, else restart i=0 and go to READ_REQ.
- READ_REQ: avm_read high for word i until waitrequest low, then READ_WAIT.
- READ_WAIT: on readdatavalid compare avm_readdata to pattern; mismatch increments error_count (saturating), captures first_err_addr if count was 0. Last word -> DONE, else i+1 -> READ_REQ.
- DONE: done high one cycle, then IDLE. Results hold until next accepted start.
- start while busy is ignored. start in DONE cycle is ignored.
- One outstanding read maximum; readdatavalid outside READ_WAIT is ignored.

## Timing
- Reset: avm_read, avm_write, busy, done = 0; error_count, first_err_addr, avm_address, avm_writedata = 0; state IDLE. Reset mid-transfer drops read/write at the next edge; no completion pulse.
- start at edge k -> busy and first avm_write/avm_read visible after edge k.
- Avalon: address, writedata, read, write stable while waitrequest high; fill sustains one word per cycle with waitrequest low.
- Check: minimum 2 cycles per word against a latency-1 slave (request cycle plus data cycle).
- done asserts the cycle after the final write accepted (fill) or final readdatavalid (check); busy falls with done.

## Structure
- Package ocram_test_pkg: state enum, op code constants (OP_FILL, OP_CHECK, OP_FILL_CHECK), ERR_CNT_MAX.
- Sub-module ocram_pattern_gen: holds index, address and pattern counters with load/advance, shared by write and compare paths.

## Test plan
- op 00, base 0, count 4, seed 16'h1234, no wait -> writes 1234,1235,1236,1237 to 0..3 on 4 consecutive cycles; done 1 cycle later; error_count 0.
- op 10, base 8190, count 4, seed 16'hFFFE, slave model -> writes FFFE,FFFF,0000,0001 to 8190,8191,0,1; readback error_count 0.
- op 01 after corrupting address 5 to 16'h0000, base 0, count 8, seed 16'h0100 -> error_count 1, first_err_addr 5.
- Random waitrequest 0-3 cycles on op 10, count 16 -> signals held stable during stalls, error_count 0, exactly 16 writes and 16 reads.
- count 0 -> done one cycle after start, no avm_read/avm_write, error_count 0.
- reset asserted mid-WRITE of count 100 -> avm_write low next cycle, busy 0, no done; subsequent start runs normally.
